// File: rtl/ramd_fifo_ctl.sv
// 32x4 synchronous FIFO controller driving an external ramdsync dual-port RAM cell.
// Optional sticky overflow/underflow flags (OVF/UNF) under `RAMD_FIFO_CTL_ERRFLAG_EN.
module ramd_fifo_ctl #(
    parameter int unsigned AFULL_LVL  = 28,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_REQ,
    input  logic [3:0] WR_DATA,
    output logic       WR_FULL,
    input  logic       RD_REQ,
    output logic [3:0] RD_DATA,
    output logic       RD_VALID,
    output logic       RD_EMPTY,
    output logic       AFULL,
    output logic       AEMPTY,
    output logic [5:0] COUNT,
    output logic [4:0] RAM_AIN,
    output logic [3:0] RAM_DIN,
    output logic       RAM_WEN,
    output logic [4:0] RAM_AOUT,
    output logic       RAM_OEN,
    input  logic [3:0] RAM_DOUT
`ifdef RAMD_FIFO_CTL_ERRFLAG_EN
    ,
    output logic       OVF,
    output logic       UNF
`endif
);

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 4;
    localparam int unsigned CW    = 6;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_cnt_nxt;

    // Acceptance; RST gating keeps the RAM strobes idle for the whole reset window.
    always_comb begin
        w_pop_ok  = RD_REQ & ~r_empty & ~RST;
        w_push_ok = WR_REQ & (~r_full | w_pop_ok) & ~RST;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointers wrap naturally at the 5-bit boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Flags are registered from the next count so they move on the same edge as cnt.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CW'(DEPTH));
            r_empty  <= (w_cnt_nxt == CW'(0));
            r_afull  <= (w_cnt_nxt >= CW'(AFULL_LVL));
            r_aempty <= (w_cnt_nxt <= CW'(AEMPTY_LVL));
        end
    end

    // Read capture from the RAM's asynchronous read port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) r_rd_data <= RAM_DOUT;
        end
    end

`ifdef RAMD_FIFO_CTL_ERRFLAG_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (WR_REQ & r_full & ~w_pop_ok) r_ovf <= 1'b1;
            if (RD_REQ & r_empty)            r_unf <= 1'b1;
        end
    end

    assign OVF = r_ovf;
    assign UNF = r_unf;
`endif

    assign RAM_AIN  = r_wr_ptr;
    assign RAM_DIN  = WR_DATA;
    assign RAM_WEN  = ~w_push_ok;
    assign RAM_AOUT = r_rd_ptr;
    assign RAM_OEN  = ~w_pop_ok;

    assign WR_FULL  = r_full;
    assign RD_EMPTY = r_empty;
    assign AFULL    = r_afull;
    assign AEMPTY   = r_aempty;
    assign COUNT    = r_cnt;
    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;

endmodule

// File: tb/tb_ramd_fifo_ctl.sv
// Bench for ramd_fifo_ctl: behavioural RAM, queue reference model, vector table and random traffic.
module tb_ramd_fifo_ctl;

    logic       clk = 1'b0;
    logic       RST;
    logic       WR_REQ;
    logic [3:0] WR_DATA;
    logic       WR_FULL;
    logic       RD_REQ;
    logic [3:0] RD_DATA;
    logic       RD_VALID;
    logic       RD_EMPTY;
    logic       AFULL;
    logic       AEMPTY;
    logic [5:0] COUNT;
    logic [4:0] RAM_AIN;
    logic [3:0] RAM_DIN;
    logic       RAM_WEN;
    logic [4:0] RAM_AOUT;
    logic       RAM_OEN;
    logic [3:0] RAM_DOUT;
`ifdef RAMD_FIFO_CTL_ERRFLAG_EN
    logic       OVF;
    logic       UNF;
`endif

    always #5 clk = ~clk;

    ramd_fifo_ctl dut (
        .CLK(clk), .RST(RST), .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL),
        .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_EMPTY(RD_EMPTY),
        .AFULL(AFULL), .AEMPTY(AEMPTY), .COUNT(COUNT), .RAM_AIN(RAM_AIN), .RAM_DIN(RAM_DIN),
        .RAM_WEN(RAM_WEN), .RAM_AOUT(RAM_AOUT), .RAM_OEN(RAM_OEN), .RAM_DOUT(RAM_DOUT)
`ifdef RAMD_FIFO_CTL_ERRFLAG_EN
        , .OVF(OVF), .UNF(UNF)
`endif
    );

    // Behavioural ramdsync: synchronous write, asynchronous read, garbage when OEN is high.
    logic [3:0] mem [32];
    always @(posedge clk) if (!RAM_WEN) mem[RAM_AIN] <= RAM_DIN;
    assign RAM_DOUT = RAM_OEN ? ~mem[RAM_AOUT] : mem[RAM_AOUT];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          q[$];
    int unsigned n_push = 0;
    int unsigned n_pop  = 0;
    logic [3:0]  exp_data = 4'h0;
    logic        exp_valid = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_unf = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_state();
        chk("rd_valid", 32'(RD_VALID), 32'(exp_valid));
        chk("rd_data",  32'(RD_DATA),  32'(exp_data));
        chk("count",    32'(COUNT),    32'(q.size()));
        chk("wr_full",  32'(WR_FULL),  32'(q.size() == 32));
        chk("rd_empty", 32'(RD_EMPTY), 32'(q.size() == 0));
        chk("afull",    32'(AFULL),    32'(q.size() >= 28));
        chk("aempty",   32'(AEMPTY),   32'(q.size() <= 4));
`ifdef RAMD_FIFO_CTL_ERRFLAG_EN
        chk("ovf", 32'(OVF), 32'(exp_ovf));
        chk("unf", 32'(UNF), 32'(exp_unf));
`endif
    endtask

    // One clock of traffic: drive at negedge, check RAM strobes, model the edge, check after it.
    task automatic step(input logic wr, input logic rd, input logic [3:0] d);
        bit full, empty, pop_ok, push_ok;
        @(negedge clk);
        WR_REQ = wr; RD_REQ = rd; WR_DATA = d;
        #1;
        full    = (q.size() == 32);
        empty   = (q.size() == 0);
        pop_ok  = rd && !empty;
        push_ok = wr && (!full || pop_ok);
        chk("ram_wen",  32'(RAM_WEN),  32'(!push_ok));
        chk("ram_oen",  32'(RAM_OEN),  32'(!pop_ok));
        chk("ram_din",  32'(RAM_DIN),  32'(d));
        chk("ram_ain",  32'(RAM_AIN),  32'(n_push % 32));
        chk("ram_aout", 32'(RAM_AOUT), 32'(n_pop % 32));
        if (wr && full && !pop_ok) exp_ovf = 1'b1;
        if (rd && empty)           exp_unf = 1'b1;
        exp_valid = pop_ok;
        if (pop_ok) begin
            exp_data = 4'(q.pop_front());
            n_pop++;
        end
        if (push_ok) begin
            q.push_back(int'(d));
            n_push++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic model_reset();
        q.delete();
        n_push = 0; n_pop = 0;
        exp_data = 4'h0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] d;
        logic       exp_valid;
        logic [3:0] exp_data;
        int         exp_count;
    } vec_t;

    vec_t tbl[7];
    int   vlen;
    int   wr_bias;
    int   rd_bias;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 1};
        tbl[1] = '{1'b1, 1'b1, 4'h7, 1'b1, 4'h3, 1};
        tbl[2] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h7, 0};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h7, 0};
        tbl[4] = '{1'b1, 1'b1, 4'hA, 1'b0, 4'h7, 1};
        tbl[5] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'hA, 0};
        tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hA, 0};

        // Reset with requests active: strobes must stay inactive.
        RST = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1; WR_DATA = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_wen", 32'(RAM_WEN), 32'(1));
        chk("rst_ram_oen", 32'(RAM_OEN), 32'(1));
        check_state();
        @(negedge clk);
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        RST = 1'b0;
        step(1'b0, 1'b0, 4'h0);

        // Vector table.
        vlen = 7;
        for (int i = 0; i < vlen; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk("tbl_valid", 32'(RD_VALID), 32'(tbl[i].exp_valid));
            chk("tbl_data",  32'(RD_DATA),  32'(tbl[i].exp_data));
            chk("tbl_count", 32'(COUNT),    32'(tbl[i].exp_count));
        end

        // Fill to 32, then a refused 33rd push.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 4'((i + 1) % 16));
        chk("fill_count", 32'(COUNT), 32'(32));
        chk("fill_full",  32'(WR_FULL), 32'(1));
        step(1'b1, 1'b0, 4'h6);
        chk("ovf_count", 32'(COUNT), 32'(32));

        // Drain 32: RD_VALID every cycle, order preserved.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 4'h0);
            chk("drain_valid", 32'(RD_VALID), 32'(1));
            chk("drain_data",  32'(RD_DATA),  32'((i + 1) % 16));
        end
        chk("drain_empty", 32'(RD_EMPTY), 32'(1));
        step(1'b0, 1'b1, 4'h0);

        // Full with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
            chk("full_rw_count", 32'(COUNT), 32'(32));
        end
        while (q.size() > 0) step(1'b0, 1'b1, 4'h0);

        // Empty with simultaneous push/pop: no fall-through.
        step(1'b1, 1'b1, 4'hA);
        chk("ft_valid", 32'(RD_VALID), 32'(0));
        chk("ft_count", 32'(COUNT), 32'(1));
        step(1'b0, 1'b1, 4'h0);
        chk("ft_data", 32'(RD_DATA), 32'(4'hA));

        // Random traffic in phases biased toward full, toward empty, then balanced.
        for (int i = 0; i < 1500; i++) begin
            wr_bias = (i < 500) ? 70 : (i < 1000) ? 30 : 50;
            rd_bias = 100 - wr_bias;
            step(32'($urandom_range(0, 99)) < 32'(wr_bias),
                 32'($urandom_range(0, 99)) < 32'(rd_bias),
                 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-cycle at COUNT = 17 during a burst.
        while (q.size() > 0) step(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        chk("pre_rst_count", 32'(COUNT), 32'(17));
        #1;
        RST = 1'b1;
        RD_REQ = 1'b1;
        #1;
        model_reset();
        chk("arst_ram_wen", 32'(RAM_WEN), 32'(1));
        chk("arst_ram_oen", 32'(RAM_OEN), 32'(1));
        check_state();
        @(negedge clk);
        RST = 1'b0; WR_REQ = 1'b0; RD_REQ = 1'b0;
        step(1'b1, 1'b0, 4'h5);
        step(1'b0, 1'b1, 4'h0);
        chk("post_rst_data",  32'(RD_DATA),  32'(4'h5));
        chk("post_rst_valid", 32'(RD_VALID), 32'(1));
        step(1'b0, 1'b0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
